// File: rtl/mem_sram_responder_pkg.sv
// Shared constants and FSM encoding for the SRAM load/store responder.
package mem_sram_responder_pkg;

    localparam int unsigned REGISTER_LEN    = 32;
    localparam int unsigned REG_ADDRESS_LEN = 4;
    localparam int unsigned ADDRESS_LEN     = 18;
    localparam int unsigned SRAM_DATA_LEN   = 16;
    localparam int unsigned MEM_BASE        = 1024;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_sram_responder_if.sv
// Half-word asynchronous SRAM bus; master is the responder, slave is the memory.
interface mem_sram_responder_if
    import mem_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDRESS_LEN,
    parameter int unsigned DATA_W = SRAM_DATA_LEN
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              we_n;
    logic              oe_n;

    modport master (output addr, output wdata, output we_n, output oe_n, input rdata);
    modport slave  (input addr, input wdata, input we_n, input oe_n, output rdata);

endinterface

// File: rtl/mem_sram_responder_sram_phase_timer.sv
// Counts the cycles an SRAM phase is held and flags the last one.
module mem_sram_responder_sram_phase_timer
    import mem_sram_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt;

    assign tc_c = run && (cnt == CNT_W'(WAIT_CYCLES));

    // Restarts from zero whenever a phase ends or no phase is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (run && !tc_c) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_sram_responder.sv
// Load/store responder: each 32-bit access runs as two half-word phases on a 16-bit async SRAM.
// Defining MEM_ADDR_CHECK_EN adds address validation and a sticky addr_err output.
module mem_sram_responder
    import mem_sram_responder_pkg::*;
#(
    parameter int unsigned DATA_LEN    = REGISTER_LEN,
    parameter int unsigned SRAM_ADDR_W = ADDRESS_LEN,
    parameter int unsigned SRAM_DATA_W = SRAM_DATA_LEN,
    parameter int unsigned MEM_BASE    = mem_sram_responder_pkg::MEM_BASE,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    input  logic [DATA_LEN-1:0]        alu_res_in,
    input  logic [DATA_LEN-1:0]        val_Rm_in,
    output logic                       wb_en_out,
    output logic                       mem_r_en_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_out,
    output logic [DATA_LEN-1:0]        alu_res_out,
    output logic [DATA_LEN-1:0]        mem_data_out,
    output logic                       ready,
`ifdef MEM_ADDR_CHECK_EN
    output logic                       addr_err,
`endif
    mem_sram_responder_if.master       sram
);

    localparam int unsigned IDX_W  = SRAM_ADDR_W - 1;
    localparam int unsigned HALF_W = SRAM_DATA_W;

    state_t                  state, state_nx;
    logic                    op_read, op_read_nx;
    logic [DATA_LEN-1:0]     data_reg, data_nx;
    logic [SRAM_ADDR_W-1:0]  addr_nx;
    logic [HALF_W-1:0]       wdata_nx;
    logic                    we_n_nx, oe_n_nx;
    logic [DATA_LEN-1:0]     offset_c;
    logic [IDX_W-1:0]        word_idx_c;
    logic                    req_c, addr_bad_c, phase_c, tc_c;
`ifdef MEM_ADDR_CHECK_EN
    logic                    err_nx;
`endif

    assign wb_en_out    = wb_en_in;
    assign mem_r_en_out = mem_r_en_in;
    assign dest_out     = dest_in;
    assign alu_res_out  = alu_res_in;
    assign mem_data_out = data_reg;

    // A non-memory instruction never stalls; a memory one is released only in DONE.
    assign req_c = mem_r_en_in | mem_w_en_in;
    assign ready = ~req_c | (state == ST_DONE);

    assign offset_c   = alu_res_in - DATA_LEN'(MEM_BASE);
    assign word_idx_c = IDX_W'(offset_c >> 2);
    assign phase_c    = (state == ST_LO) || (state == ST_HI);

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad_c = (alu_res_in < DATA_LEN'(MEM_BASE)) ||
                        (alu_res_in[1:0] != 2'b00) ||
                        ((offset_c >> (IDX_W + 2)) != '0);
`else
    assign addr_bad_c = 1'b0;
`endif

    mem_sram_responder_sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (rst),
        .run   (phase_c),
        .tc_c  (tc_c)
    );

    // Next state, read capture, and SRAM strobes for the state being entered.
    always_comb begin
        state_nx   = state;
        op_read_nx = op_read;
        data_nx    = data_reg;
        addr_nx    = '0;
        wdata_nx   = '0;
        we_n_nx    = 1'b1;
        oe_n_nx    = 1'b1;
`ifdef MEM_ADDR_CHECK_EN
        err_nx     = addr_err;
`endif

        unique case (state)
            ST_IDLE: begin
                if (req_c) begin
                    op_read_nx = mem_r_en_in;
                    if (addr_bad_c) begin
                        state_nx = ST_DONE;
                        data_nx  = '0;
`ifdef MEM_ADDR_CHECK_EN
                        err_nx   = 1'b1;
`endif
                    end else begin
                        state_nx = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (tc_c) begin
                    if (op_read) data_nx[HALF_W-1:0] = sram.rdata;
                    state_nx = ST_HI;
                end
            end
            ST_HI: begin
                if (tc_c) begin
                    if (op_read) data_nx[DATA_LEN-1:HALF_W] = sram.rdata;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
        endcase

        case (state_nx)
            ST_LO: begin
                addr_nx = {word_idx_c, 1'b0};
                if (op_read_nx) begin
                    oe_n_nx = 1'b0;
                end else begin
                    we_n_nx  = 1'b0;
                    wdata_nx = val_Rm_in[HALF_W-1:0];
                end
            end
            ST_HI: begin
                addr_nx = {word_idx_c, 1'b1};
                if (op_read_nx) begin
                    oe_n_nx = 1'b0;
                end else begin
                    we_n_nx  = 1'b0;
                    wdata_nx = val_Rm_in[DATA_LEN-1:HALF_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_read    <= 1'b0;
            data_reg   <= '0;
            sram.addr  <= '0;
            sram.wdata <= '0;
            sram.we_n  <= 1'b1;
            sram.oe_n  <= 1'b1;
        end else begin
            state      <= state_nx;
            op_read    <= op_read_nx;
            data_reg   <= data_nx;
            sram.addr  <= addr_nx;
            sram.wdata <= wdata_nx;
            sram.we_n  <= we_n_nx;
            sram.oe_n  <= oe_n_nx;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    // Sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= err_nx;
        end
    end
`endif

endmodule
